// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register indices, field positions and ExcCode values shared by the CP0 block.
package cp0_pkg;
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;
  localparam int IM_HI   = 15;
  localparam int IM_LO   = 10;
  localparam int IP_HI   = 15;
  localparam int IP_LO   = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;
  localparam int BD_BIT  = 31;
  localparam int EXC_HI  = 6;
  localparam int EXC_LO  = 2;
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;
endpackage

// File: rtl/cp0_req_arb.sv
// cp0_req_arb: combinational interrupt/exception request arbitration and ExcCode selection.
module cp0_req_arb
  import cp0_pkg::*;
(
  input  logic       ie_i,
  input  logic       exl_i,
  input  logic [5:0] im_i,
  input  logic [5:0] hw_int_i,
  input  logic       exc_valid_i,
  input  logic [4:0] exc_code_i,
  output logic       take_o,
  output logic [4:0] code_o
);
  logic irq;
  logic exq;
  assign irq    = ie_i & ~exl_i & |(hw_int_i & im_i);
  assign exq    = exc_valid_i & ~exl_i;
  assign take_o = irq | exq;
  assign code_o = irq ? EXC_INT : exc_code_i;
endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: CP0 register file (SR, Cause, EPC, PRId) with exception/interrupt entry and eret handling.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID      = 32'h4D49_5053,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        exl_clr,
  input  logic [4:0]  rd_addr,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] din,
  input  logic [31:0] pc_save,
  input  logic        bd_in,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  hw_int,
  output logic [31:0] dout,
  output logic [31:0] epc_out,
  output logic        take,
  output logic [31:0] handler_pc,
  output logic        exl
);
  logic [5:0]  im_q, im_d, ip_q;
  logic        ie_q, ie_d, exl_q, exl_d, bd_q, bd_d;
  logic [4:0]  exc_q, exc_d, code;
  logic [31:0] epc_q, epc_d, sr_val, cause_val;
  logic        wr_sr, wr_epc;
  cp0_req_arb u_arb (
    .ie_i        (ie_q),
    .exl_i       (exl_q),
    .im_i        (im_q),
    .hw_int_i    (hw_int),
    .exc_valid_i (exc_valid),
    .exc_code_i  (exc_code),
    .take_o      (take),
    .code_o      (code)
  );
  assign wr_sr  = we & (wr_addr == CP0_SR);
  assign wr_epc = we & (wr_addr == CP0_EPC);
  // SR's IM/IE follow mtc0 even while an exception is being taken; EXL and EPC yield to take.
  always_comb begin
    im_d  = wr_sr ? din[IM_HI:IM_LO] : im_q;
    ie_d  = wr_sr ? din[IE_BIT] : ie_q;
    exl_d = take ? 1'b1 : exl_clr ? 1'b0 : wr_sr ? din[EXL_BIT] : exl_q;
    epc_d = take ? (pc_save & ~32'h3) : wr_epc ? din : epc_q;
    bd_d  = take ? bd_in : bd_q;
    exc_d = take ? code : exc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q  <= '0;
      ie_q  <= 1'b0;
      exl_q <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      ie_q  <= ie_d;
      exl_q <= exl_d;
      bd_q  <= bd_d;
      ip_q  <= hw_int;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end
  always_comb begin
    sr_val                    = '0;
    sr_val[IM_HI:IM_LO]       = im_q;
    sr_val[EXL_BIT]           = exl_q;
    sr_val[IE_BIT]            = ie_q;
    cause_val                 = '0;
    cause_val[BD_BIT]         = bd_q;
    cause_val[IP_HI:IP_LO]    = ip_q;
    cause_val[EXC_HI:EXC_LO]  = exc_q;
  end
  assign dout = (rd_addr == CP0_SR)    ? sr_val :
                (rd_addr == CP0_CAUSE) ? cause_val :
                (rd_addr == CP0_EPC)   ? epc_q :
                (rd_addr == CP0_PRID)  ? PRID : 32'h0;
  assign epc_out    = epc_q;
  assign handler_pc = EXC_ENTRY;
  assign exl        = exl_q;
endmodule
